// File: rtl/m100_timer.sv
// rtl/m100_timer.sv - two-digit BCD countdown timer (99..00) with prescaled decrement
// Loads a clamped BCD preset and counts down once per TICK_CYCLES clocks while running.
module m100_timer #(
  parameter int TICK_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       t_clr,
  input  logic       t_load,
  input  logic [3:0] load_dig0,
  input  logic [3:0] load_dig1,
  input  logic       t_start,
  input  logic       t_pause,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic          start_only;
  logic          pause_only;
  logic          tick;
  logic          last_step;
  logic          nonzero;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // start and pause together cancel each other out in every state
  assign start_only = t_start & ~t_pause;
  assign pause_only = t_pause & ~t_start;
  assign tick       = (presc == PRESC_LAST);
  assign last_step  = (dig1 == 4'd0) && (dig0 == 4'd1);
  assign nonzero    = (dig0 != 4'd0) || (dig1 != 4'd0);

  assign running = (state == S_RUN);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      presc   <= '0;
      dig0    <= 4'd0;
      dig1    <= 4'd0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (t_clr) begin
        dig0  <= 4'd0;
        dig1  <= 4'd0;
        presc <= '0;
        state <= S_IDLE;
      end else if (t_load) begin
        dig0  <= clamp_bcd(load_dig0);
        dig1  <= clamp_bcd(load_dig1);
        presc <= '0;
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_only) begin
              presc <= '0;
              if (nonzero) begin
                state <= S_RUN;
              end else begin
                state   <= S_DONE;
                expired <= 1'b1;
              end
            end
          end
          S_RUN: begin
            // the RUN cycle that ends on the pause edge still counts toward the tick
            if (tick) begin
              presc <= '0;
              if (dig0 == 4'd0) begin
                dig0 <= 4'd9;
                dig1 <= dig1 - 4'd1;
              end else begin
                dig0 <= dig0 - 4'd1;
              end
              if (last_step) begin
                state   <= S_DONE;
                expired <= 1'b1;
              end else if (pause_only) begin
                state <= S_PAUSE;
              end
            end else begin
              presc <= presc + 1'b1;
              if (pause_only) state <= S_PAUSE;
            end
          end
          S_PAUSE: begin
            if (start_only) state <= S_RUN;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
